// File: rtl/core_ldst_seq.sv
// Load/store sequencer: single and multiple register transfers over a simple
// request/ready bus, with base-register writeback and load-data extraction.
module core_ldst_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load,
  input  logic [1:0]  size,
  input  logic        sign_extend,
  input  logic        increment,
  input  logic        pre_indexed,
  input  logic        writeback,
  input  logic [15:0] regs,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  output logic [3:0]  st_reg,
  input  logic [31:0] st_value,
  output logic [31:0] bus_addr,
  output logic        bus_start,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_data_wr,
  input  logic        bus_ready,
  input  logic [31:0] bus_data_rd,
  output logic        wr_en,
  output logic [3:0]  wr_reg,
  output logic [31:0] wr_value,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FINISH, S_WRITEBACK} state_t;

  state_t      state_q, state_d;
  logic        load_q, load_d;
  logic        sext_q, sext_d;
  logic        multi_q, multi_d;
  logic        wb_eff_q, wb_eff_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rn_q, rn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic        lwr_en_q, lwr_en_d;
  logic [3:0]  lwr_reg_q, lwr_reg_d;
  logic [31:0] lwr_val_q, lwr_val_d;

  function automatic logic [4:0] popcnt16(input logic [15:0] m);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, m[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) idx = i[3:0];
    return idx;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] sz,
                                               input logic [1:0] a, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   return sx ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   return sx ? {{16{h[15]}}, h} : {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] v, input logic [1:0] sz);
    case (sz)
      2'b00:   return {4{v[7:0]}};
      2'b01:   return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  logic        is_multi;
  logic [31:0] n4, eff, start_addr, final_val;
  logic        rn_loaded;
  logic [3:0]  cur_reg;
  logic [31:0] phys_addr;
  logic [3:0]  be;
  logic        last_beat;

  // Request decode, evaluated on the raw inputs so it can be latched at accept.
  always_comb begin
    is_multi  = (regs != 16'd0);
    n4        = {25'd0, popcnt16(regs), 2'b00};
    eff       = increment ? base + offset : base - offset;
    rn_loaded = load && (is_multi ? regs[rn] : (rd == rn));
    if (is_multi) begin
      start_addr = increment ? base + (pre_indexed ? 32'd4 : 32'd0)
                             : base - n4 + (pre_indexed ? 32'd0 : 32'd4);
      final_val  = increment ? base + n4 : base - n4;
    end else begin
      start_addr = pre_indexed ? eff : base;
      final_val  = eff;
    end
  end

  always_comb begin
    cur_reg   = multi_q ? lowest_idx(mask_q) : rd_q;
    last_beat = !multi_q || ((mask_q & (mask_q - 16'd1)) == 16'd0);
    case (size_q)
      2'b00: begin phys_addr = addr_q;                    be = 4'b0001 << addr_q[1:0]; end
      2'b01: begin phys_addr = {addr_q[31:1], 1'b0};      be = addr_q[1] ? 4'b1100 : 4'b0011; end
      default: begin phys_addr = {addr_q[31:2], 2'b00};   be = 4'b1111; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    sext_d    = sext_q;
    multi_d   = multi_q;
    wb_eff_d  = wb_eff_q;
    size_d    = size_q;
    mask_d    = mask_q;
    rd_d      = rd_q;
    rn_d      = rn_q;
    addr_d    = addr_q;
    wb_val_d  = wb_val_q;
    lwr_en_d  = 1'b0;
    lwr_reg_d = lwr_reg_q;
    lwr_val_d = lwr_val_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_d   = load;
          sext_d   = sign_extend;
          multi_d  = is_multi;
          size_d   = is_multi ? 2'b10 : size;
          mask_d   = regs;
          rd_d     = rd;
          rn_d     = rn;
          addr_d   = start_addr;
          wb_val_d = final_val;
          wb_eff_d = writeback && !rn_loaded;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus_ready) begin
          // Load data is registered here and written back the following cycle.
          lwr_en_d  = load_q;
          lwr_reg_d = cur_reg;
          lwr_val_d = load_extract(bus_data_rd, size_q, phys_addr[1:0], sext_q);
          addr_d    = addr_q + 32'd4;
          mask_d    = mask_q & (mask_q - 16'd1);
          if (last_beat) state_d = S_FINISH;
        end
      end
      S_FINISH:    state_d = wb_eff_q ? S_WRITEBACK : S_IDLE;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lwr_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lwr_en_q <= lwr_en_d;
    end
  end

  always_ff @(posedge clk) begin
    load_q    <= load_d;
    sext_q    <= sext_d;
    multi_q   <= multi_d;
    wb_eff_q  <= wb_eff_d;
    size_q    <= size_d;
    mask_q    <= mask_d;
    rd_q      <= rd_d;
    rn_q      <= rn_d;
    addr_q    <= addr_d;
    wb_val_q  <= wb_val_d;
    lwr_reg_q <= lwr_reg_d;
    lwr_val_q <= lwr_val_d;
  end

  // Bus outputs are gated by state so everything idles at zero.
  always_comb begin
    busy           = (state_q != S_IDLE);
    bus_start      = (state_q == S_ACCESS);
    bus_write      = bus_start && !load_q;
    bus_addr       = bus_start ? phys_addr : 32'd0;
    bus_byteenable = bus_start ? be : 4'd0;
    st_reg         = bus_start ? cur_reg : 4'd0;
    bus_data_wr    = bus_write ? store_lanes(st_value, size_q) : 32'd0;
    wr_en          = lwr_en_q || (state_q == S_WRITEBACK);
    wr_reg         = (state_q == S_WRITEBACK) ? rn_q : (lwr_en_q ? lwr_reg_q : 4'd0);
    wr_value       = (state_q == S_WRITEBACK) ? wb_val_q : (lwr_en_q ? lwr_val_q : 32'd0);
    done           = ((state_q == S_FINISH) && !wb_eff_q) || (state_q == S_WRITEBACK);
  end

endmodule

// File: tb/tb_core_ldst_seq.sv
// Scoreboard bench for core_ldst_seq: expected bus beats and register writes are
// queued when a request is issued and retired as the DUT produces them.
module tb_core_ldst_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, load = 1'b0, sign_extend = 1'b0, increment = 1'b0;
  logic        pre_indexed = 1'b0, writeback = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [15:0] regs = 16'd0;
  logic [3:0]  rd = 4'd0, rn = 4'd0;
  logic [31:0] base = 32'd0, offset = 32'd0;
  logic [3:0]  st_reg;
  logic [31:0] st_value;
  logic [31:0] bus_addr, bus_data_wr, wr_value;
  logic        bus_start, bus_write, wr_en, busy, done;
  logic [3:0]  bus_byteenable, wr_reg;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_data_rd = 32'd0;

  logic [31:0] rf [16];
  assign st_value = rf[st_reg];

  core_ldst_seq dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .size(size),
    .sign_extend(sign_extend), .increment(increment), .pre_indexed(pre_indexed),
    .writeback(writeback), .regs(regs), .rd(rd), .rn(rn), .base(base), .offset(offset),
    .st_reg(st_reg), .st_value(st_value), .bus_addr(bus_addr), .bus_start(bus_start),
    .bus_write(bus_write), .bus_byteenable(bus_byteenable), .bus_data_wr(bus_data_wr),
    .bus_ready(bus_ready), .bus_data_rd(bus_data_rd), .wr_en(wr_en), .wr_reg(wr_reg),
    .wr_value(wr_value), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] data;
  } beat_t;
  typedef struct packed {
    logic [3:0]  rg;
    logic [31:0] val;
  } wrx_t;

  beat_t exp_beat_q[$];
  wrx_t  exp_wr_q[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int stall_req = 0;
  logic ready_hold = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h8000_0000;
    return {a[15:0] ^ 16'h96E1, a[15:0] ^ 16'h5A8F};
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input logic sx);
    logic [31:0] s;
    if (sz == 2'b00) begin
      s = w >> {a[1:0], 3'b000};
      return sx ? {{24{s[7]}}, s[7:0]} : {24'd0, s[7:0]};
    end else if (sz == 2'b01) begin
      s = w >> {a[1], 4'b0000};
      return sx ? {{16{s[15]}}, s[15:0]} : {16'd0, s[15:0]};
    end
    return w;
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] a, input logic [1:0] sz,
                                    input logic wr, input logic [31:0] v);
    beat_t b;
    b.wr = wr;
    if (sz == 2'b00) begin
      b.addr = a; b.be = 4'b0001 << a[1:0]; b.data = {v[7:0], v[7:0], v[7:0], v[7:0]};
    end else if (sz == 2'b01) begin
      b.addr = {a[31:1], 1'b0}; b.be = a[1] ? 4'b1100 : 4'b0011; b.data = {v[15:0], v[15:0]};
    end else begin
      b.addr = {a[31:2], 2'b00}; b.be = 4'b1111; b.data = v;
    end
    if (!wr) b.data = 32'd0;
    return b;
  endfunction

  // Bus responder and output monitor, working half a cycle ahead of each edge.
  logic        wr_due = 1'b0, stalled_prev = 1'b0;
  int          stall_cnt = 0;
  beat_t       snap;
  always @(negedge clk) begin
    beat_t b;
    wrx_t  w;
    if (done) done_cnt++;
    if (wr_due) check_eq("wr_timing", {31'd0, wr_en}, 32'd1);
    wr_due = 1'b0;
    if (wr_en) begin
      if (exp_wr_q.size() == 0) check_eq("wr_unexpected", 32'd1, 32'd0);
      else begin
        w = exp_wr_q.pop_front();
        check_eq("wr_reg", {28'd0, wr_reg}, {28'd0, w.rg});
        check_eq("wr_value", wr_value, w.val);
      end
    end
    if (stalled_prev && bus_start) begin
      check_eq("stall_addr", bus_addr, snap.addr);
      check_eq("stall_be", {28'd0, bus_byteenable}, {28'd0, snap.be});
      check_eq("stall_data", bus_data_wr, snap.data);
    end
    stalled_prev = 1'b0;
    if (bus_start) begin
      bus_data_rd = mem_rd({bus_addr[31:2], 2'b00});
      if (ready_hold || stall_cnt < stall_req) begin
        bus_ready = 1'b0;
        stall_cnt++;
        stalled_prev = 1'b1;
        snap = '{addr: bus_addr, be: bus_byteenable, wr: bus_write, data: bus_data_wr};
      end else begin
        bus_ready = 1'b1;
        stall_cnt = 0;
        if (exp_beat_q.size() == 0) check_eq("beat_unexpected", 32'd1, 32'd0);
        else begin
          b = exp_beat_q.pop_front();
          check_eq("bus_addr", bus_addr, b.addr);
          check_eq("bus_be", {28'd0, bus_byteenable}, {28'd0, b.be});
          check_eq("bus_write", {31'd0, bus_write}, {31'd0, b.wr});
          if (b.wr) check_eq("bus_data_wr", bus_data_wr, b.data);
        end
        if (!bus_write) wr_due = 1'b1;
      end
    end else begin
      bus_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  task automatic run_op(input logic ld, input logic [1:0] sz, input logic sx, input logic inc,
                        input logic pre, input logic wbk, input logic [15:0] rm,
                        input logic [3:0] rdn, input logic [3:0] rnn,
                        input logic [31:0] b, input logic [31:0] off,
                        input int exp_lat, input logic poke_busy);
    logic [31:0] eff, a, fin;
    logic        rn_ld;
    int          n, cyc, dc0;
    n = 0;
    for (int i = 0; i < 16; i++) if (rm[i]) n++;
    if (rm == 16'd0) begin
      eff = inc ? b + off : b - off;
      a   = pre ? eff : b;
      fin = eff;
      exp_beat_q.push_back(mk_beat(a, sz, !ld, rf[rdn]));
      if (ld) exp_wr_q.push_back('{rg: rdn, val: model_ld(mem_rd({a[31:2], 2'b00}), sz, a, sx)});
      rn_ld = ld && (rdn == rnn);
    end else begin
      a   = inc ? b + (pre ? 32'd4 : 32'd0) : b - 32'(4 * n) + (pre ? 32'd0 : 32'd4);
      fin = inc ? b + 32'(4 * n) : b - 32'(4 * n);
      for (int i = 0; i < 16; i++) begin
        if (rm[i]) begin
          exp_beat_q.push_back(mk_beat(a, 2'b10, !ld, rf[i]));
          if (ld) exp_wr_q.push_back('{rg: 4'(i), val: mem_rd(a)});
          a = a + 32'd4;
        end
      end
      rn_ld = ld && rm[rnn];
    end
    if (wbk && !rn_ld) exp_wr_q.push_back('{rg: rnn, val: fin});

    dc0 = done_cnt;
    load = ld; size = sz; sign_extend = sx; increment = inc; pre_indexed = pre;
    writeback = wbk; regs = rm; rd = rdn; rn = rnn; base = b; offset = off; start = 1'b1;
    @(posedge clk); #1;
    start = poke_busy;
    load = ~ld; size = 2'(~sz); base = $urandom; offset = $urandom;
    regs = 16'hFFFF; rd = ~rdn; rn = ~rnn; increment = ~inc; writeback = ~wbk;
    cyc = 2;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 200) check_eq("done_timeout", 32'd0, 32'd1);
    else if (exp_lat != 0) check_eq("latency", 32'(cyc), 32'(exp_lat));
    @(posedge clk); #1;
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("beats_left", 32'(exp_beat_q.size()), 32'd0);
    check_eq("wr_left", 32'(exp_wr_q.size()), 32'd0);
    check_eq("done_count", 32'(done_cnt - dc0), 32'd1);
    exp_beat_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    int dc0;
    logic ld, sx, inc, pre, wbk;
    logic [1:0] sz;
    logic [3:0] rdn, rnn;
    for (int i = 0; i < 16; i++) rf[i] = {16'hC0DE, 4'(i), 4'(15 - i), 8'h5B};
    rf[5] = 32'h0000_ABCD;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_bus_start", {31'd0, bus_start}, 32'd0);
    check_eq("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_be", {28'd0, bus_byteenable}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LDRSB pre/inc and STRH post/dec with writeback
    run_op(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd2, 4'd1, 32'h1000, 32'd3, 3, 1'b0);
    run_op(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'd5, 4'd7, 32'h2002, 32'd4, 4, 1'b0);
    // LDMIA with writeback and a start pulse while busy
    run_op(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8006, 4'd0, 4'd3, 32'h100, 32'd0, 6, 1'b1);
    // Stalled single load; rd == rn so the loaded value wins over writeback
    stall_req = 3;
    run_op(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd4, 4'd4, 32'h3000, 32'd8, 6, 1'b0);
    stall_req = 0;
    // LDMDB including rn, and STMDA with writeback
    run_op(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0031, 4'd0, 4'd4, 32'h400, 32'd0, 5, 1'b0);
    run_op(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0C01, 4'd0, 4'd13, 32'h800, 32'd0, 6, 1'b0);
    // Unsigned half load at an odd address
    run_op(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd6, 4'd1, 32'h5003, 32'd0, 3, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ld = 1'($urandom); sx = 1'($urandom); inc = 1'($urandom); pre = 1'($urandom);
      wbk = 1'($urandom); sz = 2'($urandom_range(0, 2));
      rdn = 4'($urandom); rnn = 4'($urandom);
      run_op(ld, sz, sx, inc, pre, wbk, 16'h0000, rdn, rnn, $urandom, $urandom,
             (wbk && !(ld && rdn == rnn)) ? 4 : 3, 1'b0);
    end

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; regs = 16'h0000; load = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_prio_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a stalled LDM
    dc0 = done_cnt;
    ready_hold = 1'b1;
    load = 1'b1; regs = 16'h00F0; base = 32'h600; increment = 1'b1; writeback = 1'b1;
    rn = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ldm_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_bus_start", {31'd0, bus_start}, 32'd0);
    ready_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    run_op(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd2, 4'd1, 32'h1000, 32'd3, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_ldst_seq.md
CORE_LDST_SEQ -- requirements
Module: core_ldst_seq

Interface
REQ-001 SHALL have clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have start, input, 1: request pulse, sampled only in IDLE.
REQ-004 SHALL have load, input, 1: 1 = load, 0 = store.
REQ-005 SHALL have size, input, 2: 00 byte, 01 half, 10 word.
REQ-006 SHALL have sign_extend, increment, pre_indexed, writeback, inputs, 1 each: decoded addressing controls.
REQ-007 SHALL have regs, input, 16: multiple-transfer mask; 0 = single transfer.
REQ-008 SHALL have rd and rn, inputs, 4 each: single-transfer register and base register number.
REQ-009 SHALL have base, input, 32 (value of rn) and offset, input, 32 (single-transfer offset magnitude).
REQ-010 SHALL have st_reg, output, 4: register-file read select; st_value, input, 32: combinational read data.
REQ-011 SHALL have bus_addr, output, 32; bus_start, output, 1; bus_write, output, 1; bus_byteenable, output, 4; bus_data_wr, output, 32; bus_ready, input, 1; bus_data_rd, input, 32.
REQ-012 SHALL have wr_en, output, 1; wr_reg, output, 4; wr_value, output, 32: register-file write port.
REQ-013 SHALL have busy, output, 1 (state != IDLE) and done, output, 1 (one-cycle completion pulse).

Function
REQ-014 SHALL implement states IDLE, ACCESS, FINISH, WRITEBACK; IDLE->ACCESS on start; ACCESS->FINISH after last beat; FINISH->WRITEBACK if writeback is effective, else FINISH->IDLE; WRITEBACK->IDLE.
REQ-015 SHALL latch all request inputs, including base, on the accepting edge; later input changes have no effect; start while busy is ignored.
REQ-016 SHALL, single transfer: eff = increment ? base+offset : base-offset (mod 2^32); access address = pre_indexed ? eff : base; writeback value = eff.
REQ-017 SHALL, multiple transfer with N = popcount(regs): increment start = base + (pre_indexed ? 4 : 0), final = base+4N; decrement start = base-4N + (pre_indexed ? 0 : 4), final = base-4N; beats step +4; registers in ascending number order.
REQ-018 SHALL force multiple transfers to word size and ignore size/sign_extend for them.
REQ-019 SHALL drive byteenable: byte 0001<<addr[1:0]; half addr[1] ? 1100 : 0011 with bus_addr[0] forced 0; word 1111 with bus_addr[1:0] forced 00.
REQ-020 SHALL, on store, drive bus_data_wr: byte = st_value[7:0] replicated x4; half = st_value[15:0] replicated x2; word = st_value; st_reg = register of the current beat.
REQ-021 SHALL, on load, extract the enabled lane to bit 0 and zero- or sign-extend per sign_extend (word unchanged).
REQ-022 SHALL hold bus_start=1 in ACCESS with address, write, byteenable and data stable until the edge where bus_ready=1; each such edge completes one beat.
REQ-023 SHALL, for a load beat, assert wr_en with that beat's register and data in the cycle after completion; this may overlap the next beat's bus_start.
REQ-024 SHALL assert bus_start=0 in IDLE, FINISH and WRITEBACK.
REQ-025 SHALL treat writeback as effective only if writeback=1 and not (load and rn is a loaded register); loaded value wins.
REQ-026 SHALL, in WRITEBACK, assert wr_en=1, wr_reg=rn, wr_value=writeback/final value.
REQ-027 SHALL assert done for exactly one cycle, in FINISH if writeback is not effective, else in WRITEBACK.
REQ-028 SHALL, for a single zero-wait access, take 3 cycles from start edge to done (4 with writeback).

Reset
REQ-029 SHALL, on rst, enter IDLE and drive all outputs to 0 (bus_start, wr_en, done, busy, buses).
REQ-030 SHALL abandon an in-flight transfer on rst: no further wr_en or done; bus_start deasserts on the next cycle.
REQ-031 SHALL give rst priority over start in the same cycle.

Verification
REQ-032 SHALL cover: LDRSB pre/inc, base 0x1000, offset 3, rd=2, bus_data_rd=0x80000000 -> bus_addr 0x1003, byteenable 1000, r2 <= 0xFFFFFF80, no writeback.
REQ-033 SHALL cover: STRH post/dec, base 0x2002, offset 4, wb, st_value=0x0000ABCD -> addr 0x2002, byteenable 1100, data 0xABCDABCD; then rn <= 0x1FFE with done.
REQ-034 SHALL cover: LDMIA regs=0x8006, base 0x100, rn=3, wb -> addrs 0x100/0x104/0x108 load r1/r2/r15; r3 <= 0x10C; done once.
REQ-035 SHALL cover: bus_ready low 3 cycles on a beat -> bus signals stable throughout, no wr_en until completion.
REQ-036 SHALL cover: LDMDB regs includes rn, wb=1 -> loaded value written to rn, no WRITEBACK cycle, done in FINISH.
REQ-037 SHALL cover: rst asserted mid-LDM -> busy=0 and bus_start=0 next cycle, no done, next start behaves normally.
